// File: rtl/ram_burst_controller_pkg.sv
// Shared encodings for the RAM burst controller: FSM states and the
// memory-request rw / op-size codes used on the mem_* interface.
package ram_burst_controller_pkg;

  typedef enum logic [2:0] {
    RBC_IDLE       = 3'd0,
    RBC_READ       = 3'd1,
    RBC_READ_TAIL  = 3'd2,
    RBC_WRITE      = 3'd3,
    RBC_WRITE_TAIL = 3'd4
  } rbc_state_e;

  localparam logic MEM_READ      = 1'b0;
  localparam logic MEM_WRITE     = 1'b1;
  localparam logic MEM_OP_BURST  = 1'b0;
  localparam logic MEM_OP_SINGLE = 1'b1;

endpackage

// File: rtl/ram_burst_controller.sv
// Converts one granted memory request into a BURST_LEN-word line burst or a
// single-word access on a single-port synchronous block RAM.
module ram_burst_controller
  import ram_burst_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic                  mem_op_size,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_write_req,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  output logic                  mem_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned         CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]    BURST_N   = CNT_W'(BURST_LEN);

  rbc_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [CNT_W-1:0]      r_len, w_len_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]      r_wcnt, w_wcnt_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_wreq, w_wreq_nxt;
  logic                  r_wpend, w_wpend_nxt;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_accept_base;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic                  w_unused_addr_bits;

  assign w_word             = mem_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
  assign w_accept_base      = (mem_op_size == MEM_OP_SINGLE) ? w_word : (w_word & LINE_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RBC_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_wreq  <= 1'b0;
      r_wpend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_wreq  <= w_wreq_nxt;
      r_wpend <= w_wpend_nxt;
    end
  end

  // A write beat lands one cycle after its request; dropping mem_enable kills it.
  assign w_we = ((r_state == RBC_WRITE) || (r_state == RBC_WRITE_TAIL)) && r_wpend && mem_enable;

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_wcnt_nxt  = r_wcnt;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_wreq_nxt  = 1'b0;
    w_wpend_nxt = 1'b0;
    unique case (r_state)
      RBC_IDLE: begin
        if (mem_enable) begin
          w_base_nxt = w_accept_base;
          w_len_nxt  = (mem_op_size == MEM_OP_SINGLE) ? CNT_W'(1) : BURST_N;
          w_wcnt_nxt = '0;
          if (mem_rw == MEM_WRITE) begin
            w_state_nxt = RBC_WRITE;
            w_wreq_nxt  = 1'b1;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = RBC_READ;
            w_cnt_nxt   = '0;
          end
        end
      end
      RBC_READ: begin
        if (!mem_enable) begin
          w_state_nxt = RBC_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
          if (r_cnt == r_len - CNT_W'(1)) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = RBC_READ_TAIL;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      RBC_WRITE: begin
        if (!mem_enable) begin
          w_state_nxt = RBC_IDLE;
        end else begin
          w_wpend_nxt = r_wreq;
          if (w_we) begin
            w_wcnt_nxt = r_wcnt + CNT_W'(1);
          end
          if (r_cnt == r_len) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = RBC_WRITE_TAIL;
          end else begin
            w_wreq_nxt = 1'b1;
            w_cnt_nxt  = r_cnt + CNT_W'(1);
          end
        end
      end
      RBC_READ_TAIL,
      RBC_WRITE_TAIL: begin
        w_state_nxt = RBC_IDLE;
      end
      default: begin
        w_state_nxt = RBC_IDLE;
      end
    endcase
  end

  // Base is line-aligned for bursts, so base+k never leaves the line.
  assign w_addr = r_base + ((r_state == RBC_READ) ? ADDR_WIDTH'(r_cnt) : ADDR_WIDTH'(r_wcnt));

  assign ram_addr       = ((r_state == RBC_READ) || w_we) ? w_addr : '0;
  assign ram_we         = w_we;
  assign ram_wdata      = w_we ? mem_write : '0;
  assign mem_read       = r_valid ? ram_rdata : '0;
  assign mem_read_valid = r_valid;
  assign mem_last       = r_last;
  assign mem_write_req  = r_wreq;
  assign busy           = (r_state != RBC_IDLE);

endmodule

// File: tb/tb_ram_burst_controller.sv
// Self-checking bench for ram_burst_controller with a behavioural block RAM.
module tb_ram_burst_controller;
  import ram_burst_controller_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned BL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   mem_addr;
  logic          mem_enable;
  logic          mem_rw;
  logic          mem_op_size;
  logic [DW-1:0] mem_write;
  logic          mem_write_req;
  logic [DW-1:0] mem_read;
  logic          mem_read_valid;
  logic          mem_last;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  logic [DW-1:0] bram    [0:65535];
  logic [DW-1:0] exp_mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_burst_controller #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_enable    (mem_enable),
    .mem_rw        (mem_rw),
    .mem_op_size   (mem_op_size),
    .mem_write     (mem_write),
    .mem_write_req (mem_write_req),
    .mem_read      (mem_read),
    .mem_read_valid(mem_read_valid),
    .mem_last      (mem_last),
    .busy          (busy),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  // single_port_bram: synchronous read, one-cycle latency, plus a preload port
  always @(posedge clk) begin
    if (pre_we) bram[pre_addr] <= pre_data;
    else if (ram_we) bram[ram_addr] <= ram_wdata;
    ram_rdata <= bram[ram_addr];
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({mem_write_req, mem_read_valid, mem_last, busy, ram_we} !== 5'b0) begin
      failures++;
      $display("FAIL %s ctrl got=%b exp=00000", tag, {mem_write_req, mem_read_valid, mem_last, busy, ram_we});
    end
    checks++;
    if (ram_addr !== '0) begin failures++; $display("FAIL %s ram_addr got=%h exp=0", tag, ram_addr); end
    checks++;
    if (ram_wdata !== '0) begin failures++; $display("FAIL %s ram_wdata got=%h exp=0", tag, ram_wdata); end
    checks++;
    if (mem_read !== '0) begin failures++; $display("FAIL %s mem_read got=%h exp=0", tag, mem_read); end
  endtask

  task automatic run_read(input logic [31:0] addr, input logic single, input string tag);
    logic [AW-1:0] base;
    logic [DW-1:0] rq[$];
    logic [DW-1:0] got;
    int n;
    n    = single ? 1 : int'(BL);
    base = single ? AW'(addr >> 2) : AW'(((addr >> 2) / BL) * BL);
    for (int i = 0; i < n; i++) rq.push_back(exp_mem[AW'(base + AW'(i))]);
    mem_addr = addr; mem_rw = MEM_READ; mem_op_size = single; mem_enable = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= n + 1; j++) begin
      #1;
      if (j == n + 1) mem_enable = 1'b0;
      #1;
      checks++;
      if (busy !== (j <= n)) begin failures++; $display("FAIL %s busy j=%0d got=%b exp=%b", tag, j, busy, (j <= n)); end
      if (j < n) begin
        checks++;
        if (ram_addr !== AW'(base + AW'(j))) begin
          failures++; $display("FAIL %s ram_addr j=%0d got=%h exp=%h", tag, j, ram_addr, AW'(base + AW'(j)));
        end
      end
      checks++;
      if (mem_read_valid !== (j >= 1 && j <= n)) begin
        failures++; $display("FAIL %s read_valid j=%0d got=%b exp=%b", tag, j, mem_read_valid, (j >= 1 && j <= n));
      end
      checks++;
      if (mem_last !== (j == n)) begin failures++; $display("FAIL %s last j=%0d got=%b exp=%b", tag, j, mem_last, (j == n)); end
      checks++;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL %s ram_we j=%0d got=%b exp=0", tag, j, ram_we); end
      if (mem_read_valid === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          failures++; $display("FAIL %s rd_extra j=%0d got=%h exp=none", tag, j, mem_read);
        end else begin
          got = rq.pop_front();
          if (mem_read !== got) begin failures++; $display("FAIL %s rd_data j=%0d got=%h exp=%h", tag, j, mem_read, got); end
        end
      end
      if (j <= n) @(posedge clk);
    end
    checks++;
    if (rq.size() != 0) begin failures++; $display("FAIL %s rd_missing got=%0d exp=0", tag, rq.size()); end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic single, input logic [DW-1:0] dbase, input string tag);
    logic [AW-1:0] base;
    logic [AW-1:0] aq[$];
    logic [DW-1:0] dq[$];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic prev_req;
    int n, k;
    n    = single ? 1 : int'(BL);
    base = single ? AW'(addr >> 2) : AW'(((addr >> 2) / BL) * BL);
    prev_req = 1'b0; k = 0;
    mem_addr = addr; mem_rw = MEM_WRITE; mem_op_size = single; mem_enable = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= n + 1; j++) begin
      #1;
      if (prev_req) begin
        ed = dbase + DW'(k);
        mem_write = ed;
        aq.push_back(AW'(base + AW'(k)));
        dq.push_back(ed);
        exp_mem[AW'(base + AW'(k))] = ed;
        k++;
      end
      if (j == n + 1) mem_enable = 1'b0;
      #1;
      prev_req = mem_write_req;
      checks++;
      if (mem_write_req !== (j < n)) begin failures++; $display("FAIL %s write_req j=%0d got=%b exp=%b", tag, j, mem_write_req, (j < n)); end
      checks++;
      if (ram_we !== (j >= 1 && j <= n)) begin failures++; $display("FAIL %s ram_we j=%0d got=%b exp=%b", tag, j, ram_we, (j >= 1 && j <= n)); end
      checks++;
      if (mem_last !== (j == n)) begin failures++; $display("FAIL %s last j=%0d got=%b exp=%b", tag, j, mem_last, (j == n)); end
      if (ram_we === 1'b1) begin
        checks++;
        if (aq.size() == 0) begin
          failures++; $display("FAIL %s wr_extra j=%0d got=%h exp=none", tag, j, ram_addr);
        end else begin
          ea = aq.pop_front(); ed = dq.pop_front();
          if (ram_addr !== ea || ram_wdata !== ed) begin
            failures++; $display("FAIL %s wr_beat j=%0d got=%h:%h exp=%h:%h", tag, j, ram_addr, ram_wdata, ea, ed);
          end
        end
      end
      if (j == n + 1) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_end got=%b exp=0", tag, busy); end
      end
      if (j <= n) @(posedge clk);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bram[AW'(base + AW'(i))] !== exp_mem[AW'(base + AW'(i))]) begin
        failures++;
        $display("FAIL %s ram_word %h got=%h exp=%h", tag, AW'(base + AW'(i)), bram[AW'(base + AW'(i))], exp_mem[AW'(base + AW'(i))]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_enable = 1'b0; mem_addr = '0; mem_rw = MEM_READ;
    mem_op_size = MEM_OP_BURST; mem_write = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #2;
    check_all_zero("reset");
    for (int i = 0; i < 8; i++) preload(AW'(8 + i), DW'(32'hA0 + i));
    for (int i = 0; i < 8; i++) preload(AW'(16'hFFF8 + i), DW'(32'hF000 + i));
    preload(AW'(16'h41), 32'hC0FFEE41);
    mem_enable = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_enable_held");
    mem_enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release busy got=%b exp=0", busy); end
  endtask

  task automatic test_read_burst();   run_read(32'h24, MEM_OP_BURST, "read_burst"); endtask
  task automatic test_write_burst();  run_write(32'h40, MEM_OP_BURST, 32'h100, "write_burst"); endtask
  task automatic test_single_read();  run_read(32'h104, MEM_OP_SINGLE, "single_read"); endtask
  task automatic test_top_of_space(); run_read(32'h3FFE0, MEM_OP_BURST, "top_of_space"); endtask

  task automatic test_single_write();
    run_write(32'h208, MEM_OP_SINGLE, 32'h55AA0000, "single_write");
    run_read(32'h208, MEM_OP_SINGLE, "single_readback");
  endtask

  task automatic test_back_to_back();
    run_read(32'h40, MEM_OP_BURST, "b2b_read");
    run_write(32'h64, MEM_OP_BURST, 32'h200, "b2b_write");
    run_read(32'h60, MEM_OP_BURST, "b2b_readback");
  endtask

  task automatic test_abort();
    int reqs, writes, lasts;
    logic prev_req;
    reqs = 0; writes = 0; lasts = 0; prev_req = 1'b0;
    mem_addr = 32'h800; mem_rw = MEM_WRITE; mem_op_size = MEM_OP_BURST; mem_enable = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 7; j++) begin
      #1;
      if (prev_req) mem_write = 32'hDEAD0000 + DW'(j);
      if (reqs >= 3) mem_enable = 1'b0;
      #1;
      prev_req = mem_write_req;
      if (mem_write_req === 1'b1 && mem_enable === 1'b1) reqs++;
      if (ram_we === 1'b1) writes++;
      if (mem_last === 1'b1) lasts++;
      if (j >= 4) begin
        checks++;
        if (busy !== 1'b0 || mem_write_req !== 1'b0) begin
          failures++; $display("FAIL abort_idle j=%0d got=%b%b exp=00", j, busy, mem_write_req);
        end
      end
      @(posedge clk);
    end
    checks++;
    if (reqs != 3) begin failures++; $display("FAIL abort_reqs got=%0d exp=3", reqs); end
    checks++;
    if (writes > 3) begin failures++; $display("FAIL abort_writes got=%0d exp=<=3", writes); end
    checks++;
    if (lasts != 0) begin failures++; $display("FAIL abort_last got=%0d exp=0", lasts); end
    #2;
    run_read(32'h24, MEM_OP_BURST, "after_abort");
  endtask

  task automatic test_reset_mid();
    mem_addr = 32'h24; mem_rw = MEM_READ; mem_op_size = MEM_OP_BURST; mem_enable = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    check_all_zero("reset_mid_hold");
    mem_enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_release busy got=%b exp=0", busy); end
    run_read(32'h24, MEM_OP_BURST, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_single_read();
    test_single_write();
    test_top_of_space();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
